// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with a registered one-hot grant held for a multi-cycle
// transaction; released on done, abandonment or watchdog expiry.
module rr_arbiter_onehot #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    localparam int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          busy,
    output logic          timeout
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [N-1:0]  prio_mask_q, prio_mask_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  masked;
    logic [N-1:0]  cand;
    logic [N-1:0]  win;
    logic [HW-1:0] hold_inc;
    logic          expire;
    logic          abandon;

    // Highest set bit wins. A log-depth prefix-OR marks every position that
    // has a set bit at or above it; a bit survives only if nothing above is set.
    function automatic logic [N-1:0] msb_onehot(input logic [N-1:0] x);
        logic [N-1:0] s;
        s = x;
        for (int k = 1; k < N; k = k * 2) begin
            s = s | (s >> k);
        end
        return x & ~(s >> 1);
    endfunction

    function automatic logic [IW-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) idx = idx | IW'(i);
        end
        return idx;
    endfunction

    always_comb begin
        masked   = req & prio_mask_q;
        cand     = (|masked) ? masked : req;
        win      = msb_onehot(cand);
        hold_inc = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + HW'(1);
        expire   = (MAX_HOLD != 0) && (hold_inc == HOLD_SAT);
        abandon  = ~|(req & gnt_q);
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        prio_mask_d = prio_mask_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = BUSY;
                    gnt_d       = win;
                    gnt_idx_d   = onehot_to_idx(win);
                    // (1<<k)-1: only indices below the new owner are preferred next
                    prio_mask_d = win - N'(1);
                    hold_cnt_d  = '0;
                end
            end
            BUSY: begin
                hold_cnt_d = hold_inc;
                if (done || abandon || expire) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                    timeout_d  = expire && !done;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            prio_mask_q <= '1;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            prio_mask_q <= prio_mask_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign busy    = (state_q == BUSY);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// Bench for rr_arbiter_onehot: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the round-robin rules.
module tb_rr_arbiter_onehot;

    localparam int N        = 8;
    localparam int MAX_HOLD = 4;
    localparam int IW       = 3;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          busy;
    logic          timeout;

    int n_cmp;
    int n_fail;

    // Behavioural model: current owner (-1 idle), last granted index
    // (indices below it are preferred), busy cycles held, timeout pulse.
    int m_owner;
    int m_last;
    int m_hold;
    bit m_timeout;

    rr_arbiter_onehot #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    function automatic int pick(input logic [N-1:0] r, input int below);
        for (int i = below - 1; i >= 0; i--) if (r[i]) return i;
        for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] v;
        v = '0;
        if (m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] bit_of(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_last    = N;
        m_hold    = 0;
        m_timeout = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic d);
        bit exp_hit;
        m_timeout = 0;
        if (m_owner < 0) begin
            if (r != '0) begin
                m_owner = pick(r, m_last);
                m_last  = m_owner;
                m_hold  = 0;
            end
        end else begin
            exp_hit = (MAX_HOLD != 0) && (m_hold + 1 >= MAX_HOLD);
            if (d || !r[m_owner] || exp_hit) begin
                m_timeout = exp_hit && !d;
                m_owner   = -1;
                m_hold    = 0;
            end else begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    // Advance one clock with the current inputs, then settle to the sample point.
    task automatic tick();
        model_edge(req, done);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        req   = '0;
        done  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++;
        if (gnt !== 8'h00) begin
            n_fail++; $display("FAIL reset_gnt actual=%h required=00", gnt);
        end
        n_cmp++;
        if (gnt_idx !== 3'd0) begin
            n_fail++; $display("FAIL reset_gnt_idx actual=%0d required=0", gnt_idx);
        end
        n_cmp++;
        if (busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_timeout actual=%b%b required=00", busy, timeout);
        end
    endtask

    task automatic test_first_grant();
        reset_dut();
        req = 8'b1010_0001;
        tick();
        n_cmp++;
        if (gnt !== 8'h80 || gnt_idx !== 3'd7 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant actual=gnt %h idx %0d busy %b required=gnt 80 idx 7 busy 1", gnt, gnt_idx, busy);
        end
    endtask

    task automatic test_rotation();
        int exp_own[4] = '{5, 0, 7, 5};
        reset_dut();
        req = 8'b1010_0001;
        tick();
        n_cmp++;
        if (gnt !== 8'h80) begin
            n_fail++; $display("FAIL rot_start actual=%h required=80", gnt);
        end
        for (int i = 0; i < 4; i++) begin
            done = 1'b1;
            tick();
            n_cmp++;
            if (gnt !== 8'h00 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rot_bubble%0d actual=%h required=00", i, gnt);
            end
            done = 1'b0;
            tick();
            n_cmp++;
            if (gnt !== bit_of(exp_own[i]) || gnt_idx !== IW'(exp_own[i])) begin
                n_fail++;
                $display("FAIL rot_owner%0d actual=%h/%0d required=%h/%0d", i, gnt, gnt_idx, bit_of(exp_own[i]), exp_own[i]);
            end
        end
    endtask

    task automatic test_abandon();
        reset_dut();
        req = 8'b1010_0001;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 8'h20) begin
            n_fail++; $display("FAIL abandon_setup actual=%h required=20", gnt);
        end
        req = 8'b1110_0001;
        tick();
        n_cmp++;
        if (gnt !== 8'h20) begin
            n_fail++; $display("FAIL abandon_nonowner_req actual=%h required=20", gnt);
        end
        req = 8'b1100_0001;
        tick();
        n_cmp++;
        if (gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL abandon_release actual=gnt %h busy %b to %b required=gnt 00 busy 0 to 0", gnt, busy, timeout);
        end
        tick();
        n_cmp++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            n_fail++; $display("FAIL abandon_next actual=%h required=01", gnt);
        end
    endtask

    task automatic test_watchdog();
        reset_dut();
        req = 8'h08;
        tick();
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            tick();
            n_cmp++;
            if (gnt !== 8'h08 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL wd_hold%0d actual=%h/%b required=08/0", i, gnt, timeout);
            end
        end
        tick();
        n_cmp++;
        if (gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_release actual=gnt %h busy %b to %b required=gnt 00 busy 0 to 1", gnt, busy, timeout);
        end
        req = 8'h0C;
        tick();
        n_cmp++;
        if (gnt !== 8'h04 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL wd_next actual=%h/%b required=04/0", gnt, timeout);
        end
    endtask

    task automatic test_done_timeout();
        reset_dut();
        req = 8'h08;
        tick();
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL done_vs_wd actual=%h/%b required=00/0", gnt, timeout);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        req = 8'b1010_0001;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset actual=%h/%b required=00/0", gnt, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        req = 8'hFF;
        tick();
        n_cmp++;
        if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
            n_fail++; $display("FAIL after_reset_grant actual=%h required=80", gnt);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            req  = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 3) == 0) req = '0;
            done = ($urandom_range(0, 4) == 0);
            tick();
            n_cmp++;
            if (gnt !== exp_gnt() || busy !== (m_owner >= 0) || timeout !== m_timeout) begin
                n_fail++;
                $display("FAIL rand_c%0d actual=gnt %h busy %b to %b required=gnt %h busy %b to %b",
                         c, gnt, busy, timeout, exp_gnt(), (m_owner >= 0), m_timeout);
            end
            if (m_owner >= 0) begin
                n_cmp++;
                if (gnt_idx !== IW'(m_owner)) begin
                    n_fail++; $display("FAIL rand_idx_c%0d actual=%0d required=%0d", c, gnt_idx, m_owner);
                end
            end
        end
        done = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        req    = '0;
        done   = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        test_reset();
        test_first_grant();
        test_rotation();
        test_abandon();
        test_watchdog();
        test_done_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
